// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - front-end hazard sequencer for the 5-stage pipeline
//
// Purpose:
//   Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble.
//   It stalls on load-use hazards and squashes wrong-path fetches after a taken branch
//   that was resolved in EX. It also freezes the front end while data memory is busy.
//
// Parameters:
//   REG_ADDR_W   register-file index width
//   FLUSH_CYCLES cycles of IF/ID + ID/EX squash per taken branch (1..4)
//   CNT_W        perf counter width; this parameter exists only when HAZARD_PERF_CNT_EN is defined
//
// Ports:
//   clk, rst                  rising-edge clock; asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt  source registers of the instruction in ID
//   ex_mem_read, ex_rd        load flag and destination register of the instruction in EX
//   ex_branch_taken           branch in EX resolved taken
//   mem_busy                  data memory not ready, so the whole front end holds
//   pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active   control outputs
//   stall_cycles, flush_events  saturating perf counters, present only when HAZARD_PERF_CNT_EN is defined
//
// Configuration macro: HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_WAIT_MEM = 2'd2;

  // FLUSH holds for fcnt+1 further cycles after the branch cycle itself.
  localparam logic [1:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  logic [1:0] state, state_nxt;
  logic [1:0] fcnt, fcnt_nxt;
  logic       load_use;

  // r0 is hardwired to zero, so a load that targets r0 never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    if (!rst) begin
      // The outputs are forced while reset is asserted, independent of the clock.
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      state_nxt     = ST_RUN;
      fcnt_nxt      = 2'd0;
    end else if (state == ST_FLUSH) begin
      if (mem_busy) begin
        // The squash is paused: the front end is frozen and fcnt and state are held.
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
      end else begin
        // The wrong path is still in flight, so branch and load-use inputs are ignored.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (fcnt == 2'd0) state_nxt = ST_RUN;
        else              fcnt_nxt  = fcnt - 2'd1;
      end
    end else begin
      // RUN, and WAIT_MEM once memory is ready, share the same evaluation.
      if (mem_busy) begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        state_nxt     = ST_WAIT_MEM;
      end else if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = FCNT_INIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end else if (load_use) begin
        // A single bubble is enough: the load leaves EX on the next edge.
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_bubble   = 1'b1;
        state_nxt     = ST_RUN;
      end else begin
        state_nxt = ST_RUN;
      end
    end
  end

  assign stall_active = !pc_write_en || !ifid_write_en || ifid_flush || idex_bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      fcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_accept;

  // A taken branch is accepted only when it is evaluated as RUN and memory is ready.
  assign flush_accept = (state != ST_FLUSH) && !mem_busy && ex_branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_accept && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;

  // Expected output vectors, ordered {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active}.
  localparam logic [4:0] V_RST  = 5'b00111;
  localparam logic [4:0] V_NORM = 5'b11000;
  localparam logic [4:0] V_LU   = 5'b00011;
  localparam logic [4:0] V_BR   = 5'b11111;
  localparam logic [4:0] V_HOLD = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [1:0] stall_cycles, flush_events;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .FLUSH_CYCLES(FC)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .CNT_W       (2)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .pc_write_en    (pc_write_en),
    .ifid_write_en  (ifid_write_en),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .stall_active   (stall_active)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs 1 ns after the edge. If chk is set, it also queues the expected outputs.
  task automatic cyc(input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt, input logic br, input logic mb,
                     input logic [4:0] exp, input logic chk, input string tag);
    @(posedge clk);
    #1;
    rst = r; ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; ex_branch_taken = br; mem_busy = mb;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
  endtask

  task automatic idle(input logic [4:0] exp, input string tag);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, exp, 1, tag);
  endtask

  // Outputs are combinational, so they are sampled mid-cycle, well clear of the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {27'd0, pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active}, {27'd0, e});
    end
  end

  initial begin
    // Test 1: reset values, then RUN after release.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, V_RST, 1, "reset");
    idle(V_NORM, "release");
    idle(V_NORM, "run");

    // Test 2: load-use hazards.
    cyc(1, 1, 5, 5, 0, 0, 0, 0, V_LU, 1, "lu_rs");
    idle(V_NORM, "lu_one_cycle");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, V_NORM, 1, "lu_r0");
    cyc(1, 1, 5, 3, 5, 0, 0, 0, V_NORM, 1, "lu_rt_unused");
    cyc(1, 1, 5, 3, 5, 1, 0, 0, V_LU, 1, "lu_rt_used");
    cyc(1, 0, 5, 3, 5, 1, 0, 0, V_NORM, 1, "lu_cleared");

    // Test 3: taken-branch squash. A second pulse during FLUSH is ignored.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, V_BR, 1, "br_0");
    for (int i = 1; i < FC; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, V_BR, 1, "br_flush");
    idle(V_NORM, "br_done");
    // Branch plus load-use in the same cycle: the branch wins.
    cyc(1, 1, 7, 7, 0, 0, 1, 0, V_BR, 1, "br_over_lu");
    for (int i = 1; i < FC; i++) cyc(1, 1, 7, 7, 0, 0, 0, 0, V_BR, 1, "flush_ign_lu");
    idle(V_NORM, "br_lu_done");

    // Test 4: memory busy.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, V_HOLD, 1, "mem_hold");
    idle(V_NORM, "mem_release");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, V_HOLD, 1, "mem_over_br");
    cyc(1, 0, 0, 0, 0, 0, 1, 1, V_HOLD, 1, "mem_over_br");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, V_BR, 1, "br_after_mem");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, V_NORM, 0, "settle");
    idle(V_NORM, "after_mem_br");
    // mem_busy during FLUSH freezes the squash.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, V_BR, 1, "br_pre_mem");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, V_HOLD, 1, "flush_mem_hold");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, V_HOLD, 1, "flush_mem_hold");
    for (int i = 1; i < FC; i++) idle(V_BR, "flush_resume");
    idle(V_NORM, "flush_mem_done");

    // Test 5: reset in the middle of an operation.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, V_BR, 1, "br_pre_rst");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, V_RST, 1, "rst_in_flush");
    idle(V_NORM, "no_leftover_flush");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, V_HOLD, 1, "wait_mem");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, V_RST, 1, "rst_in_wait");
    idle(V_NORM, "no_leftover_wait");

`ifdef HAZARD_PERF_CNT_EN
    // Test 6: saturating perf counters with CNT_W=2.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, V_RST, 1, "perf_rst");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 9, 9, 0, 0, 0, 0, V_LU, 1, "perf_lu");
      idle(V_NORM, "perf_lu_done");
    end
    check_eq("stall_cycles_sat", {30'd0, stall_cycles}, 32'd3);
    check_eq("flush_events_zero", {30'd0, flush_events}, 32'd0);
    for (int b = 0; b < 2; b++) begin
      cyc(1, 0, 0, 0, 0, 0, 1, 0, V_BR, 1, "perf_br");
      for (int i = 1; i < FC; i++) idle(V_BR, "perf_flush");
      idle(V_NORM, "perf_br_done");
    end
    idle(V_NORM, "perf_tail");
    check_eq("flush_events", {30'd0, flush_events}, 32'd2);
    check_eq("stall_cycles_hold", {30'd0, stall_cycles}, 32'd3);
`endif

    @(negedge clk);
    @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
